// File: rtl/midi_tx.sv
// MIDI note-event transmitter: latches note-on/off events, builds 3-byte
// channel-voice messages (optionally using running status) and shifts them out
// as back-to-back 8N1 UART frames at CLKS_PER_BIT clocks per bit.
module midi_tx #(
    parameter int unsigned CLKS_PER_BIT   = 320,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       evValid_i,
    output logic       evReady_o,
    input  logic       evNoteOn_i,
    input  logic [3:0] ch_i,
    input  logic [6:0] note_i,
    input  logic [6:0] vel_i,
    output logic       txData_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       data1_q, data1_d;
    logic [7:0]       data2_q, data2_d;
    logic [7:0]       last_status_q, last_status_d;
    logic             last_valid_q, last_valid_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [7:0]       cur_byte;
    logic [7:0]       new_status;
    logic [2:0]       next_bit;
    logic             bit_end;
    logic             skip_status;

    // Byte currently being serialized and helpers shared by the FSM
    always_comb begin
        cur_byte    = (byte_q == 2'd0) ? status_q : ((byte_q == 2'd1) ? data1_q : data2_q);
        new_status  = {1'b1, 2'b00, evNoteOn_i, ch_i};
        next_bit    = bit_q + 3'd1;
        bit_end     = (cnt_q == CNT_MAX);
        skip_status = (RUNNING_STATUS != 0) && last_valid_q && (new_status == last_status_q);
    end

    // State and datapath registers; reset forces the line idle and forgets running status
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            byte_q        <= '0;
            status_q      <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            last_status_q <= '0;
            last_valid_q  <= 1'b0;
            tx_q          <= 1'b1;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            status_q      <= status_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
            tx_q          <= tx_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state, baud timing, byte/bit sequencing and registered line value
    always_comb begin
        state_d       = state_q;
        cnt_d         = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_d         = bit_q;
        byte_d        = byte_q;
        status_d      = status_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        tx_d          = tx_q;
        ready_d       = ready_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (evValid_i && ready_q) begin
                    status_d      = new_status;
                    data1_d       = {1'b0, note_i};
                    data2_d       = {1'b0, vel_i};
                    byte_d        = skip_status ? 2'd1 : 2'd0;
                    bit_d         = '0;
                    last_status_d = new_status;
                    last_valid_d  = 1'b1;
                    state_d       = START;
                    tx_d          = 1'b0;
                    ready_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_byte[next_bit];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q != 2'd2) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        busy_d = !ready_d;
    end

    assign evReady_o = ready_q;
    assign busy_o    = busy_q;
    assign txData_o  = tx_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: a message-level model predicts the serial line and ready
// for every cycle, a UART decoder recovers bytes for literal byte checks.
module tb_midi_tx;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ev_valid, ev_valid0;
    logic       ev_note_on;
    logic [3:0] ev_ch;
    logic [6:0] ev_note, ev_vel;
    logic       ready, tx, busy;
    logic       ready0, tx0, busy0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    midi_tx #(.CLKS_PER_BIT(N), .RUNNING_STATUS(1)) dut (
        .clk_i(clk), .nrst_i(rst_n), .evValid_i(ev_valid), .evReady_o(ready),
        .evNoteOn_i(ev_note_on), .ch_i(ev_ch), .note_i(ev_note), .vel_i(ev_vel),
        .txData_o(tx), .busy_o(busy)
    );

    midi_tx #(.CLKS_PER_BIT(N), .RUNNING_STATUS(0)) dut0 (
        .clk_i(clk), .nrst_i(rst_n), .evValid_i(ev_valid0), .evReady_o(ready0),
        .evNoteOn_i(ev_note_on), .ch_i(ev_ch), .note_i(ev_note), .vel_i(ev_vel),
        .txData_o(tx0), .busy_o(busy0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- message-level model ----------------
    bit         qa[$];
    bit         qb[$];
    logic [7:0] ls[2]    = '{8'h00, 8'h00};
    bit         lv[2]    = '{1'b0, 1'b0};
    logic       eline[2] = '{1'b1, 1'b1};
    logic       erdy[2]  = '{1'b1, 1'b1};
    int         cyc = 0;
    int         acc_prev = 0;
    int         acc_last = 0;

    task automatic push_frame(input int m, input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            bit v;
            v = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
            for (int r = 0; r < int'(N); r++) begin
                if (m == 0) qa.push_back(v);
                else        qb.push_back(v);
            end
        end
    endtask

    // Predicts each cycle's line level and ready from accepted events
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            for (int m = 0; m < 2; m++) begin
                lv[m]    = 1'b0;
                eline[m] = 1'b1;
                erdy[m]  = 1'b1;
            end
        end else begin
            cyc++;
            for (int m = 0; m < 2; m++) begin
                logic       vld;
                logic [7:0] st;
                int         sz;
                vld = (m == 0) ? ev_valid : ev_valid0;
                if (erdy[m] && vld) begin
                    st = (ev_note_on ? 8'h90 : 8'h80) | {4'h0, ev_ch};
                    if (!((m == 0) && lv[m] && (st == ls[m]))) push_frame(m, st);
                    push_frame(m, {1'b0, ev_note});
                    push_frame(m, {1'b0, ev_vel});
                    ls[m] = st;
                    lv[m] = 1'b1;
                    if (m == 0) begin
                        acc_prev = acc_last;
                        acc_last = cyc;
                    end
                end
                sz = (m == 0) ? qa.size() : qb.size();
                if (sz > 0) begin
                    eline[m] = (m == 0) ? qa.pop_front() : qb.pop_front();
                    erdy[m]  = 1'b0;
                end else begin
                    eline[m] = 1'b1;
                    erdy[m]  = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("line",   32'(tx),     32'(eline[0]));
            check("ready",  32'(ready),  32'(erdy[0]));
            check("busy",   32'(busy),   32'(!erdy[0]));
            check("line0",  32'(tx0),    32'(eline[1]));
            check("ready0", 32'(ready0), 32'(erdy[1]));
            check("busy0",  32'(busy0),  32'(!erdy[1]));
        end
    end

    // ---------------- UART decoder on the main DUT ----------------
    logic [7:0] rxq[$];
    logic [7:0] rxb;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (N / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (N) @(negedge clk);
                    rxb[j] = tx;
                end
                repeat (N) @(negedge clk);
                check("stop_bit", 32'(tx), 32'd1);
                rxq.push_back(rxb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int m, input logic on, input logic [3:0] c,
                        input logic [6:0] nt, input logic [6:0] v);
        int k;
        @(negedge clk);
        ev_note_on = on;
        ev_ch      = c;
        ev_note    = nt;
        ev_vel     = v;
        if (m == 0) ev_valid = 1'b1;
        else        ev_valid0 = 1'b1;
        for (k = 0; k < 2000; k++) begin
            if ((m == 0) ? ready : ready0) break;
            @(negedge clk);
        end
        if (k == 2000) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        ev_valid  = 1'b0;
        ev_valid0 = 1'b0;
    endtask

    task automatic measure(input int m, output int n);
        int k;
        n = 0;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!((m == 0) ? busy : busy0)) break;
            n++;
        end
        if (k == 2000) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] e);
        int k;
        for (k = 0; k < 400; k++) begin
            if (rxq.size() > 0) break;
            @(negedge clk);
        end
        if (rxq.size() == 0) check({nm, "_missing"}, 32'd1, 32'd0);
        else                 check(nm, 32'(rxq.pop_front()), 32'(e));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n      = 1'b0;
        ev_valid   = 1'b0;
        ev_valid0  = 1'b0;
        ev_note_on = 1'b0;
        ev_ch      = '0;
        ev_note    = '0;
        ev_vel     = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_line",  32'(tx),    32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full message from reset
        send(0, 1'b1, 4'd2, 7'd60, 7'd100);
        measure(0, n);
        check("full_len", 32'(n), 32'd120);
        expect_byte("m1_status", 8'h92);
        expect_byte("m1_note",   8'h3C);
        expect_byte("m1_vel",    8'h64);

        // Running status: identical event repeats without the status byte
        send(0, 1'b1, 4'd2, 7'd60, 7'd100);
        measure(0, n);
        check("rs_len", 32'(n), 32'd80);
        expect_byte("m2_note", 8'h3C);
        expect_byte("m2_vel",  8'h64);

        // Running status disabled: always three bytes
        send(1, 1'b1, 4'd2, 7'd60, 7'd100);
        measure(1, n);
        check("nors_len1", 32'(n), 32'd120);
        send(1, 1'b1, 4'd2, 7'd60, 7'd100);
        measure(1, n);
        check("nors_len2", 32'(n), 32'd120);

        // Type change forces the status byte
        send(0, 1'b0, 4'd2, 7'd60, 7'd0);
        measure(0, n);
        check("off_len", 32'(n), 32'd120);
        expect_byte("m3_status", 8'h82);
        expect_byte("m3_note",   8'h3C);
        expect_byte("m3_vel",    8'h00);

        // Backpressure: second event raised mid-message waits for ready
        send(0, 1'b1, 4'd5, 7'd10, 7'd20);
        repeat (10) @(negedge clk);
        check("bp_ready_low", 32'(ready), 32'd0);
        send(0, 1'b1, 4'd5, 7'd11, 7'd22);
        check("bp_gap", 32'(acc_last - acc_prev), 32'd121);
        measure(0, n);
        check("bp_len2", 32'(n), 32'd80);
        expect_byte("m4_status", 8'h95);
        expect_byte("m4_note",   8'h0A);
        expect_byte("m4_vel",    8'h14);
        expect_byte("m5_note",   8'h0B);
        expect_byte("m5_vel",    8'h16);

        // Reset mid-message, then the next message must be sent in full
        send(0, 1'b1, 4'd2, 7'd60, 7'd100);
        repeat (49) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_line",  32'(tx),    32'd1);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_busy",  32'(busy),  32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        rxq.delete();
        send(0, 1'b1, 4'd2, 7'd60, 7'd100);
        measure(0, n);
        check("post_rst_len", 32'(n), 32'd120);
        expect_byte("m6_status", 8'h92);
        expect_byte("m6_note",   8'h3C);
        expect_byte("m6_vel",    8'h64);

        // Sweep all channels with extreme note numbers
        for (int c = 0; c < 16; c++) begin
            logic       on;
            logic [6:0] nt;
            on = (c % 2 == 0);
            nt = on ? 7'd0 : 7'd127;
            send(0, on, 4'(c), nt, 7'(c));
            measure(0, n);
            check("sweep_len", 32'(n), 32'd120);
            expect_byte("sweep_status", (on ? 8'h90 : 8'h80) + 8'(c));
            expect_byte("sweep_note",   {1'b0, nt});
            expect_byte("sweep_vel",    8'(c));
        end

        repeat (20) @(negedge clk);
        check("rx_extra", 32'(rxq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
